// File: rtl/constants.sv
// rtl/constants.sv - shared design constants
package constants;
    localparam int WORD_LENGTH = 8;
endpackage

// File: rtl/_demux16_buf_if.sv
// rtl/_demux16_buf_if.sv - producer/consumer bundle of the 16-slot demux buffer
interface _demux16_buf_if #(parameter int n = constants::WORD_LENGTH);
    logic [3:0]   sel;
    logic [n-1:0] in;
    logic         in_valid;
    logic         in_ready;
    logic [n-1:0] out00, out01, out02, out03, out04, out05, out06, out07;
    logic [n-1:0] out08, out09, out10, out11, out12, out13, out14, out15;
    logic [15:0]  out_valid;
    logic [15:0]  out_ready;
    logic [4:0]   occupancy;

    modport master (
        output sel, in, in_valid, out_ready,
        input  in_ready, out_valid, occupancy,
        input  out00, out01, out02, out03, out04, out05, out06, out07,
        input  out08, out09, out10, out11, out12, out13, out14, out15
    );

    modport slave (
        input  sel, in, in_valid, out_ready,
        output in_ready, out_valid, occupancy,
        output out00, out01, out02, out03, out04, out05, out06, out07,
        output out08, out09, out10, out11, out12, out13, out14, out15
    );
endinterface

// File: rtl/_demux16_buf.sv
// rtl/_demux16_buf.sv - 1-to-16 demultiplexer with a one-entry buffer per slot
module _demux16_buf #(
    parameter int n = constants::WORD_LENGTH
) (
    input  logic          clk,
    input  logic          rst,
    _demux16_buf_if.slave bus
);
    logic [n-1:0] r_data [16];
    logic [15:0]  r_valid;
    logic [4:0]   r_occ;

    logic         w_ready;
    logic         w_acc;
    logic [15:0]  w_acc_vec;
    logic [15:0]  w_dlv;
    logic [4:0]   w_dlv_cnt;

    // A full slot still accepts when its consumer drains it on the same edge.
    assign w_ready   = !rst && (!r_valid[bus.sel] || bus.out_ready[bus.sel]);
    assign w_acc     = bus.in_valid && w_ready;
    assign w_acc_vec = w_acc ? (16'd1 << bus.sel) : 16'd0;
    assign w_dlv     = r_valid & bus.out_ready;

    always_comb begin
        w_dlv_cnt = 5'd0;
        for (int i = 0; i < 16; i++) begin
            w_dlv_cnt = w_dlv_cnt + {4'd0, w_dlv[i]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) begin
                r_data[i] <= '0;
            end
            r_valid <= 16'd0;
            r_occ   <= 5'd0;
        end else begin
            if (w_acc) begin
                r_data[bus.sel] <= bus.in;
            end
            r_valid <= (r_valid & ~w_dlv) | w_acc_vec;
            r_occ   <= r_occ + {4'd0, w_acc} - w_dlv_cnt;
        end
    end

    assign bus.in_ready  = w_ready;
    assign bus.out_valid = r_valid;
    assign bus.occupancy = r_occ;

    assign bus.out00 = r_data[0];
    assign bus.out01 = r_data[1];
    assign bus.out02 = r_data[2];
    assign bus.out03 = r_data[3];
    assign bus.out04 = r_data[4];
    assign bus.out05 = r_data[5];
    assign bus.out06 = r_data[6];
    assign bus.out07 = r_data[7];
    assign bus.out08 = r_data[8];
    assign bus.out09 = r_data[9];
    assign bus.out10 = r_data[10];
    assign bus.out11 = r_data[11];
    assign bus.out12 = r_data[12];
    assign bus.out13 = r_data[13];
    assign bus.out14 = r_data[14];
    assign bus.out15 = r_data[15];
endmodule

// File: tb/tb__demux16_buf.sv
// tb/tb__demux16_buf.sv - self-checking bench for _demux16_buf
module tb__demux16_buf;
    localparam int N = constants::WORD_LENGTH;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    _demux16_buf_if #(.n(N)) bif ();
    _demux16_buf #(.n(N)) dut (.clk(clk), .rst(rst), .bus(bif));

    logic [N-1:0] outs [16];
    assign outs[0]  = bif.out00;
    assign outs[1]  = bif.out01;
    assign outs[2]  = bif.out02;
    assign outs[3]  = bif.out03;
    assign outs[4]  = bif.out04;
    assign outs[5]  = bif.out05;
    assign outs[6]  = bif.out06;
    assign outs[7]  = bif.out07;
    assign outs[8]  = bif.out08;
    assign outs[9]  = bif.out09;
    assign outs[10] = bif.out10;
    assign outs[11] = bif.out11;
    assign outs[12] = bif.out12;
    assign outs[13] = bif.out13;
    assign outs[14] = bif.out14;
    assign outs[15] = bif.out15;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bif.in_valid = 1'b0;
        bif.out_ready = 16'd0;
        step();
        rst = 1'b0;
    endtask

    logic [N-1:0] m_data [16];
    logic [15:0]  m_v;
    int           n_acc;
    int           n_dlv;
    logic         exp_rdy;

    initial begin
        rst = 1'b1;
        bif.sel = 4'd0;
        bif.in = '0;
        bif.in_valid = 1'b0;
        bif.out_ready = 16'd0;
        step();
        step();
        #1;
        check("rst_in_ready", 32'(bif.in_ready), 32'd0);
        check("rst_out_valid", 32'(bif.out_valid), 32'd0);
        check("rst_occ", 32'(bif.occupancy), 32'd0);
        check("rst_out05", 32'(outs[5]), 32'd0);

        // single word to slot 5
        rst = 1'b0;
        bif.in_valid = 1'b1; bif.sel = 4'd5; bif.in = 8'hA5;
        #1;
        check("first_in_ready", 32'(bif.in_ready), 32'd1);
        step();
        bif.in_valid = 1'b0;
        check("single_out05", 32'(outs[5]), 32'hA5);
        check("single_out_valid", 32'(bif.out_valid), 32'h0020);
        check("single_occ", 32'(bif.occupancy), 32'd1);
        check("single_out04", 32'(outs[4]), 32'd0);

        // stalled offer to full slot 3, other slot proceeds
        do_reset();
        bif.in_valid = 1'b1; bif.sel = 4'd3; bif.in = 8'h55;
        step();
        bif.in = 8'h11;
        for (int c = 0; c < 3; c++) begin
            #1;
            check("stall_in_ready", 32'(bif.in_ready), 32'd0);
            step();
            check("stall_out03", 32'(outs[3]), 32'h55);
        end
        bif.sel = 4'd4;
        #1;
        check("other_in_ready", 32'(bif.in_ready), 32'd1);
        step();
        bif.in_valid = 1'b0;
        check("other_out04", 32'(outs[4]), 32'h11);
        check("other_occ", 32'(bif.occupancy), 32'd2);

        // same-edge deliver and accept on slot 7
        do_reset();
        bif.in_valid = 1'b1; bif.sel = 4'd7; bif.in = 8'h22;
        step();
        bif.in = 8'h33; bif.out_ready = 16'h0080;
        #1;
        check("thru_in_ready", 32'(bif.in_ready), 32'd1);
        step();
        bif.in_valid = 1'b0; bif.out_ready = 16'd0;
        check("thru_out07", 32'(outs[7]), 32'h33);
        check("thru_out_valid", 32'(bif.out_valid), 32'h0080);
        check("thru_occ", 32'(bif.occupancy), 32'd1);

        // fill all 16 slots, then drain together
        do_reset();
        for (int i = 0; i < 16; i++) begin
            bif.in_valid = 1'b1; bif.sel = 4'(i); bif.in = 8'(8'h80 + i);
            step();
        end
        bif.in_valid = 1'b1;
        check("full_occ", 32'(bif.occupancy), 32'd16);
        check("full_out_valid", 32'(bif.out_valid), 32'hFFFF);
        for (int i = 0; i < 16; i++) begin
            bif.sel = 4'(i);
            #1;
            check("full_in_ready", 32'(bif.in_ready), 32'd0);
        end
        bif.in_valid = 1'b0;
        bif.out_ready = 16'hFFFF;
        step();
        bif.out_ready = 16'd0;
        check("drain_out_valid", 32'(bif.out_valid), 32'd0);
        check("drain_occ", 32'(bif.occupancy), 32'd0);
        for (int i = 0; i < 16; i++) begin
            check("drain_retain", 32'(outs[i]), 32'(8'h80 + i));
        end

        // reset wins over a same-edge accept
        bif.in_valid = 1'b1; bif.sel = 4'd9; bif.in = 8'h44;
        rst = 1'b1;
        #1;
        check("rstacc_in_ready", 32'(bif.in_ready), 32'd0);
        step();
        rst = 1'b0;
        check("rstacc_out_valid", 32'(bif.out_valid), 32'd0);
        check("rstacc_out09", 32'(outs[9]), 32'd0);
        check("rstacc_occ", 32'(bif.occupancy), 32'd0);
        #1;
        check("postrst_in_ready", 32'(bif.in_ready), 32'd1);
        step();
        bif.in_valid = 1'b0;
        check("postrst_out09", 32'(outs[9]), 32'h44);
        check("postrst_out_valid", 32'(bif.out_valid), 32'h0200);

        // random traffic against a per-slot model
        do_reset();
        m_v = 16'd0;
        n_acc = 0;
        n_dlv = 0;
        for (int i = 0; i < 16; i++) m_data[i] = '0;
        for (int c = 0; c < 10000; c++) begin
            bif.in_valid  = 1'($urandom_range(0, 1));
            bif.sel       = 4'($urandom_range(0, 15));
            bif.in        = 8'(c);
            bif.out_ready = 16'($urandom);
            #1;
            exp_rdy = !m_v[bif.sel] || bif.out_ready[bif.sel];
            check("rnd_in_ready", 32'(bif.in_ready), 32'(exp_rdy));
            for (int i = 0; i < 16; i++) begin
                if (m_v[i] && bif.out_ready[i]) begin
                    check("rnd_deliver", 32'(outs[i]), 32'(m_data[i]));
                    n_dlv++;
                    m_v[i] = 1'b0;
                end
            end
            if (bif.in_valid && exp_rdy) begin
                m_data[bif.sel] = bif.in;
                m_v[bif.sel] = 1'b1;
                n_acc++;
            end
            step();
            check("rnd_out_valid", 32'(bif.out_valid), 32'(m_v));
            check("rnd_occ", 32'(bif.occupancy), 32'($countones(bif.out_valid)));
        end
        check("rnd_conserve", 32'(n_acc), 32'(n_dlv + $countones(m_v)));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/_demux16_buf.md
_DEMUX16_BUF -- requirements
Module: _demux16_buf

Interface
REQ-001 The block SHALL take parameter: n, default constants::WORD_LENGTH, data width in bits of the input and of each output slot.
REQ-002 The block SHALL have port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port: rst  input  1  reset, synchronous and active-high.
REQ-004 The block SHALL have port: sel  input  4  destination slot index 0..15 for the current input word.
REQ-005 The block SHALL have port: in  input  n  data word to deliver.
REQ-006 The block SHALL have port: in_valid  input  1  producer offers in/sel this cycle.
REQ-007 The block SHALL have port: in_ready  output  1  block accepts the offered word this cycle.
REQ-008 The block SHALL have ports: out00..out15  output  n each  registered data of slot 00..15.
REQ-009 The block SHALL have port: out_valid  output  16  bit i set means slot i holds an undelivered word.
REQ-010 The block SHALL have port: out_ready  input  16  bit i set means consumer i takes slot i this cycle.
REQ-011 The block SHALL have port: occupancy  output  5  number of set out_valid bits, range 0..16.

Function
REQ-012 The block SHALL hold 16 one-entry buffers, each an n-bit data register plus a valid bit driving outXX and out_valid[XX].
REQ-013 The block SHALL drive in_ready = !rst && (!out_valid[sel] || out_ready[sel]), combinationally, independent of in_valid.
REQ-014 The block SHALL accept when in_valid && in_ready at a rising edge: data register of slot sel <= in, out_valid[sel] <= 1.
REQ-015 The block SHALL make accepted data visible one cycle after the accepting edge; no combinational path from in to any outXX.
REQ-016 The block SHALL deliver slot i when out_valid[i] && out_ready[i] at a rising edge: out_valid[i] <= 0, unless REQ-017 applies.
REQ-017 The block SHALL, on same-edge deliver and accept of slot i, keep out_valid[i]=1 and load the new word (full throughput, one word per cycle per slot).
REQ-018 The block SHALL allow any number of slots to deliver on the same edge, independently.
REQ-019 The block SHALL ignore out_ready[i] when out_valid[i]=0.
REQ-020 The block SHALL ignore sel and in when in_valid=0, with no state change from them.
REQ-021 The block SHALL hold outXX stable while out_valid[XX]=1 and out_ready[XX]=0.
REQ-022 The block SHALL retain the last written value on outXX after delivery (valid=0); data registers change only on accept or reset.
REQ-023 The block SHALL update occupancy on the same edge as out_valid: next = current + accept - deliveries, with an accept-and-deliver on one slot netting 0; occupancy SHALL always equal popcount(out_valid).
REQ-024 The block SHALL, with all 16 slots valid and out_ready=0, drive in_ready=0 for every sel and change no state.
REQ-025 The block SHALL, with slot sel valid and not ready, stall only that offer; other slots continue delivering.

Reset
REQ-026 The block SHALL, on any rising edge with rst=1, clear all data registers to 0, out_valid to 0, occupancy to 0.
REQ-027 The block SHALL give rst priority over a same-edge accept or deliver; the word offered is dropped (in_ready=0 while rst=1).
REQ-028 The block SHALL, on the first edge after rst falls, accept normally (in_ready=1 for every sel).

Verification
REQ-029 Bench SHALL cover: after reset, in_valid=1, sel=5, in=0xA5 for one cycle -> next cycle out05=0xA5, out_valid=0x0020, occupancy=1; others 0.
REQ-030 Bench SHALL cover: slot 3 valid, out_ready=0, offer sel=3 in=0x11 -> in_ready=0 for all cycles held; out03 unchanged; offer sel=4 same cycle -> accepted, occupancy 2.
REQ-031 Bench SHALL cover: slot 7 valid with 0x22, same cycle out_ready[7]=1 and accept sel=7 in=0x33 -> out07=0x33, out_valid[7]=1, occupancy unchanged.
REQ-032 Bench SHALL cover: fill sel 0..15 over 16 cycles with out_ready=0 -> occupancy=16, out_valid=0xFFFF, in_ready=0; then out_ready=0xFFFF one cycle -> out_valid=0, occupancy=0, outXX retain data.
REQ-033 Bench SHALL cover: rst=1 on the same edge as accept sel=9 in=0x44 -> out_valid=0, out09=0, occupancy=0; first edge after rst accepts.
REQ-034 Bench SHALL cover: random in_valid/sel/out_ready for 10k cycles against a scoreboard -> every accepted word delivered exactly once, in order per slot, occupancy == popcount(out_valid) every cycle.
